// File: rtl/prirv32_exu_mc.sv
`default_nettype none
// ============================================================================
// prirv32_exu_mc : multi-cycle ALU / branch-compare execute unit   (rev 1.0)
// ============================================================================
module prirv32_exu_mc #(
  parameter int XLEN         = 32,
  parameter int SERIAL_SHIFT = 0,
  parameter int SHIFT_STEP   = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            flush_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_out,
  output logic            cmp_out,
  output logic [4:0]      rd_out,
  output logic            busy_out
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] C_STEP = (SHW+1)'(SHIFT_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, work_q, work_d;
  logic            cmp_q, cmp_d;
  logic [4:0]      rd_q, rd_d;
  logic [SHW:0]    rem_q, rem_d;
  logic            left_q, left_d, arith_q, arith_d;

  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_sum, w_diff, w_sll, w_srl, w_sra;
  logic [XLEN-1:0] w_alu_res, w_work_nxt, w_sra_step;
  logic            w_alu_cmp, w_lt, w_ltu, w_is_shift, w_serial_go, w_load;
  logic [SHW:0]    w_step, w_rem_nxt;

  assign w_shamt     = rs2_in[SHW-1:0];
  assign w_sum       = rs1_in + rs2_in;
  assign w_diff      = rs1_in - rs2_in;
  assign w_lt        = $signed(rs1_in) < $signed(rs2_in);
  assign w_ltu       = rs1_in < rs2_in;
  assign w_is_shift  = (op_in == 4'd2) || (op_in == 4'd6) || (op_in == 4'd7);
  assign w_serial_go = (SERIAL_SHIFT != 0) && w_is_shift && (w_shamt != '0);

  // In serial mode the single-cycle path only ever sees shamt == 0.
  generate
    if (SERIAL_SHIFT != 0) begin : g_serial
      assign w_sll = rs1_in;
      assign w_srl = rs1_in;
      assign w_sra = rs1_in;
    end else begin : g_barrel
      assign w_sll = rs1_in << w_shamt;
      assign w_srl = rs1_in >> w_shamt;
      assign w_sra = $signed(rs1_in) >>> w_shamt;
    end
  endgenerate

  assign w_step     = (rem_q >= C_STEP) ? C_STEP : rem_q;
  assign w_rem_nxt  = rem_q - w_step;
  assign w_sra_step = $signed(work_q) >>> w_step;
  assign w_work_nxt = left_q  ? (work_q << w_step) :
                      arith_q ? w_sra_step : (work_q >> w_step);

  always_comb begin
    w_alu_res = '0;
    w_alu_cmp = 1'b0;
    case (op_in)
      4'd0:  w_alu_res = w_sum;
      4'd1:  w_alu_res = w_diff;
      4'd2:  w_alu_res = w_sll;
      4'd3:  begin w_alu_cmp = w_lt;  w_alu_res = {{(XLEN-1){1'b0}}, w_lt};  end
      4'd4:  begin w_alu_cmp = w_ltu; w_alu_res = {{(XLEN-1){1'b0}}, w_ltu}; end
      4'd5:  w_alu_res = rs1_in ^ rs2_in;
      4'd6:  w_alu_res = w_srl;
      4'd7:  w_alu_res = w_sra;
      4'd8:  w_alu_res = rs1_in | rs2_in;
      4'd9:  w_alu_res = rs1_in & rs2_in;
      4'd10: begin w_alu_cmp = (rs1_in == rs2_in); w_alu_res = w_diff; end
      4'd11: begin w_alu_cmp = (rs1_in != rs2_in); w_alu_res = w_diff; end
      4'd12: begin w_alu_cmp = !w_lt;  w_alu_res = w_diff; end
      4'd13: begin w_alu_cmp = !w_ltu; w_alu_res = w_diff; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cmp_d    = cmp_q;
    rd_d     = rd_q;
    work_d   = work_q;
    rem_d    = rem_q;
    left_d   = left_q;
    arith_d  = arith_q;
    w_load   = 1'b0;
    if (flush_in) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: w_load = in_valid;
        S_SHIFT: begin
          work_d = w_work_nxt;
          rem_d  = w_rem_nxt;
          if (w_rem_nxt == '0) begin
            result_d = w_work_nxt;
            cmp_d    = 1'b0;
            state_d  = S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            w_load = in_valid;
            if (!in_valid) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (w_load) begin
        rd_d = rd_in;
        if (w_serial_go) begin
          state_d = S_SHIFT;
          work_d  = rs1_in;
          rem_d   = {1'b0, w_shamt};
          left_d  = (op_in == 4'd2);
          arith_d = (op_in == 4'd7);
        end else begin
          result_d = w_alu_res;
          cmp_d    = w_alu_cmp;
          state_d  = S_HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      cmp_q    <= 1'b0;
      rd_q     <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cmp_q    <= cmp_d;
      rd_q     <= rd_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      left_q   <= left_d;
      arith_q  <= arith_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign out_valid  = (state_q == S_HOLD);
  assign busy_out   = (state_q == S_SHIFT);
  assign result_out = result_q;
  assign cmp_out    = cmp_q;
  assign rd_out     = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_prirv32_exu_mc.sv
`default_nettype none
// ============================================================================
// tb_prirv32_exu_mc : barrel and serial-shift instances against a reference model (rev 1.0)
// ============================================================================
module tb_prirv32_exu_mc;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, sel;
  logic [3:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;

  logic        iv_b, iv_s, rdy_b, rdy_s, vld_b, vld_s, cmp_b, cmp_s, busy_b, busy_s;
  logic [31:0] res_b, res_s;
  logic [4:0]  rdo_b, rdo_s;
  logic        o_ready, o_valid, o_cmp, o_busy;
  logic [31:0] o_res;
  logic [4:0]  o_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign iv_b    = in_valid & ~sel;
  assign iv_s    = in_valid & sel;
  assign o_ready = sel ? rdy_s  : rdy_b;
  assign o_valid = sel ? vld_s  : vld_b;
  assign o_cmp   = sel ? cmp_s  : cmp_b;
  assign o_busy  = sel ? busy_s : busy_b;
  assign o_res   = sel ? res_s  : res_b;
  assign o_rd    = sel ? rdo_s  : rdo_b;

  prirv32_exu_mc #(.XLEN(32), .SERIAL_SHIFT(0), .SHIFT_STEP(4)) u_bar (
    .clk_in(clk), .rst_in(rst), .flush_in(flush), .in_valid(iv_b), .in_ready(rdy_b),
    .op_in(op), .rs1_in(rs1), .rs2_in(rs2), .rd_in(rd), .out_valid(vld_b),
    .out_ready(out_ready), .result_out(res_b), .cmp_out(cmp_b), .rd_out(rdo_b),
    .busy_out(busy_b));

  prirv32_exu_mc #(.XLEN(32), .SERIAL_SHIFT(1), .SHIFT_STEP(4)) u_ser (
    .clk_in(clk), .rst_in(rst), .flush_in(flush), .in_valid(iv_s), .in_ready(rdy_s),
    .op_in(op), .rs1_in(rs1), .rs2_in(rs2), .rd_in(rd), .out_valid(vld_s),
    .out_ready(out_ready), .result_out(res_s), .cmp_out(cmp_s), .rd_out(rdo_s),
    .busy_out(busy_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values, shifts as multiply/divide.
  function automatic void ref_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic c);
    longint unsigned ua, ub, p, un;
    longint          sa, sb;
    logic [31:0]     na;
    int              sh;
    ua = a;
    ub = b;
    sa = a[31] ? longint'(ua) - 64'sd4294967296 : longint'(ua);
    sb = b[31] ? longint'(ub) - 64'sd4294967296 : longint'(ub);
    sh = int'(ub % 32);
    p  = 1;
    for (int i = 0; i < sh; i++) p = p * 2;
    na = ~a;
    un = na;
    r  = 32'd0;
    c  = 1'b0;
    case (f)
      4'd0:  r = 32'(ua + ub);
      4'd1:  r = 32'(ua + 64'd4294967296 - ub);
      4'd2:  r = 32'(ua * p);
      4'd3:  begin c = (sa < sb); r = c ? 32'd1 : 32'd0; end
      4'd4:  begin c = (ua < ub); r = c ? 32'd1 : 32'd0; end
      4'd5:  r = a ^ b;
      4'd6:  r = 32'(ua / p);
      4'd7:  r = a[31] ? ~32'(un / p) : 32'(ua / p);
      4'd8:  r = a | b;
      4'd9:  r = a & b;
      4'd10: begin c = (ua == ub); r = 32'(ua + 64'd4294967296 - ub); end
      4'd11: begin c = (ua != ub); r = 32'(ua + 64'd4294967296 - ub); end
      4'd12: begin c = (sa >= sb); r = 32'(ua + 64'd4294967296 - ub); end
      4'd13: begin c = (ua >= ub); r = 32'(ua + 64'd4294967296 - ub); end
      default: ;
    endcase
  endfunction

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_op(input logic s, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t, input int stall);
    logic [31:0] er;
    logic        ec;
    int          lat, cyc, bz, sh;
    ref_op(f, a, b, er, ec);
    sh  = int'(b % 32);
    lat = (s && (f == 4'd2 || f == 4'd6 || f == 4'd7) && sh != 0) ? (sh + 3) / 4 + 1 : 1;
    sel = s;
    #1;
    check("in_ready_pre", {31'd0, o_ready}, 32'd1);
    in_valid = 1'b1; op = f; rs1 = a; rs2 = b; rd = t;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = (stall == 0);
    cyc = 1;
    bz  = 0;
    while (!o_valid && cyc < 64) begin
      if (o_busy) bz++;
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, lat);
    check("busy_cycles", bz, lat - 1);
    check("result", o_res, er);
    check("cmp", {31'd0, o_cmp}, {31'd0, ec});
    check("rd", {27'd0, o_rd}, {27'd0, t});
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, o_valid}, 32'd1);
      check("hold_result", o_res, er);
      check("hold_in_ready", {31'd0, o_ready}, 32'd0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    logic rose;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
    op = 4'd0; rs1 = 32'd0; rs2 = 32'd0; rd = 5'd0;
    #2;
    check("rst_valid_b", {31'd0, vld_b}, 32'd0);
    check("rst_result_b", res_b, 32'd0);
    check("rst_valid_s", {31'd0, vld_s}, 32'd0);
    check("rst_busy_s", {31'd0, busy_s}, 32'd0);
    check("rst_rd_s", {27'd0, rdo_s}, 32'd0);
    check("rst_cmp_b", {31'd0, cmp_b}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst_b", {31'd0, rdy_b}, 32'd1);
    check("ready_after_rst_s", {31'd0, rdy_s}, 32'd1);
    @(posedge clk); #1;

    do_op(1'b0, 4'd0,  32'hFFFF_FFFF, 32'd1, 5'd1, 0);
    do_op(1'b0, 4'd1,  32'd5, 32'd7, 5'd2, 0);
    do_op(1'b0, 4'd3,  32'h8000_0000, 32'd1, 5'd3, 0);
    do_op(1'b0, 4'd4,  32'h8000_0000, 32'd1, 5'd4, 0);
    do_op(1'b0, 4'd13, 32'd3, 32'd3, 5'd5, 0);
    do_op(1'b0, 4'd11, 32'd3, 32'd3, 5'd6, 0);
    do_op(1'b0, 4'd7,  32'h8000_0000, 32'd31, 5'd7, 0);
    do_op(1'b0, 4'd14, 32'h1234_5678, 32'd9, 5'd8, 0);
    do_op(1'b1, 4'd7,  32'h8000_0000, 32'd31, 5'd9, 0);
    do_op(1'b1, 4'd2,  32'hCAFE_F00D, 32'd0, 5'd10, 0);
    do_op(1'b1, 4'd15, 32'hCAFE_F00D, 32'd3, 5'd11, 0);

    // Backpressure then back-to-back issue on the release cycle.
    sel = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; op = 4'd5; rs1 = 32'h0000_F0F0; rs2 = 32'h0000_0FF0; rd = 5'd12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_first", res_b, 32'h0000_FF00);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_stable", o_res, 32'h0000_FF00);
      check("bp_in_ready", {31'd0, o_ready}, 32'd0);
      check("bp_valid", {31'd0, o_valid}, 32'd1);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; op = 4'd0; rs1 = 32'd10; rs2 = 32'd20; rd = 5'd13;
    #1;
    check("b2b_ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_valid", {31'd0, o_valid}, 32'd1);
    check("b2b_result", o_res, 32'd30);
    check("b2b_rd", {27'd0, o_rd}, 32'd13);

    // Flush during a serial SRL with 8 shift cycles.
    sel = 1'b1;
    in_valid = 1'b1; op = 4'd6; rs1 = 32'hDEAD_BEEF; rs2 = 32'd31; rd = 5'd14;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_valid", {31'd0, o_valid}, 32'd0);
    check("flush_busy", {31'd0, o_busy}, 32'd0);
    check("flush_ready", {31'd0, o_ready}, 32'd1);
    rose = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (o_valid) rose = 1'b1;
    end
    check("flush_no_valid", {31'd0, rose}, 32'd0);

    // Flush coincident with an accept drops that op.
    sel = 1'b0;
    in_valid = 1'b1; flush = 1'b1; op = 4'd0; rs1 = 32'd1; rs2 = 32'd1; rd = 5'd15;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_acc_valid", {31'd0, o_valid}, 32'd0);
    @(posedge clk); #1;
    check("flush_acc_valid2", {31'd0, o_valid}, 32'd0);

    // Asynchronous reset mid-shift.
    sel = 1'b1;
    in_valid = 1'b1; op = 4'd7; rs1 = 32'h9ABC_DEF0; rs2 = 32'd29; rd = 5'd16;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, vld_s}, 32'd0);
    check("arst_busy", {31'd0, busy_s}, 32'd0);
    check("arst_result", res_s, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(1'b1, 4'd0, 32'd2, 32'd2, 5'd17, 0);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a, b;
      logic [3:0]  f;
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      f = 4'($urandom_range(0, 15));
      do_op(1'($urandom_range(0, 1)), f, a, b, 5'($urandom_range(0, 31)),
            int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prirv32_exu_mc.md
Name: prirv32_exu_mc

Overview:
- Parametrised, multi-cycle successor to the priRV32 integer execute unit.
- Accepts one ALU/branch-compare operation per handshake using a compact 4-bit opcode instead of the one-hot instruction bus.
- Shifts run as a single-cycle barrel or as an iterative serial shifter, selected by parameter.
- Results and the branch-condition bit are registered and held under valid/ready backpressure toward the writeback stage; a flush input aborts in-flight work.

Parameters:
- XLEN, 32, datapath width in bits; must be a power of two, at least 8.
- SERIAL_SHIFT, 0, 0 = single-cycle barrel shifter; 1 = iterative shifter.
- SHIFT_STEP, 4, bits shifted per cycle when SERIAL_SHIFT=1; power of two, 1 to XLEN.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- flush_in  input  1  synchronous abort of the current operation and pending result.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept an operation this cycle.
- op_in  input  4  opcode: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 EQ, 11 NE, 12 GE, 13 GEU; 14 and 15 reserved.
- rs1_in  input  XLEN  operand A.
- rs2_in  input  XLEN  operand B; immediate is already muxed in upstream.
- rd_in  input  5  destination tag, passed through.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result_out  output  XLEN  operation result.
- cmp_out  output  1  comparison bit: branch-taken flag for ops 10 to 13, SLT/SLTU bit for ops 3 and 4, 0 otherwise.
- rd_out  output  5  latched destination tag.
- busy_out  output  1  high in SHIFT state.

Behaviour:
- Reset state: IDLE. out_valid=0, result_out=0, cmp_out=0, rd_out=0, busy_out=0. in_ready=1 once reset deasserts.
- FSM states: IDLE, SHIFT, HOLD.
- Accept = in_valid && in_ready. Operands, op and rd are latched on accept.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This allows back-to-back issue.
- Single-cycle ops: all ops except shifts, and all shifts when SERIAL_SHIFT=0.
  - Result is registered on the accept edge; out_valid rises on the next cycle; state goes to HOLD.
  - Latency is 1 cycle.
- Serial shifts (SERIAL_SHIFT=1, op 2, 6 or 7):
  - Shift amount = rs2_in[$clog2(XLEN)-1:0].
  - On accept: load the working register with rs1 and the remaining count with the shift amount, then go to SHIFT.
  - Each SHIFT cycle shifts by min(SHIFT_STEP, remaining) and decrements remaining by the same amount.
  - When remaining reaches 0: result registered, go to HOLD.
  - Latency = ceil(shamt/SHIFT_STEP)+1 cycles.
  - shamt=0 is a 1-cycle latency with result=rs1; it does not pass through SHIFT.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN; no overflow flag.
  - SRA replicates rs1[XLEN-1]; SRL fills with zeros.
  - SLT, SLT-based GE and all other signed compares use two's-complement ordering. SLTU and GEU are unsigned.
  - SLT/SLTU result_out = zero-extended cmp bit.
  - For EQ/NE/GE/GEU: result_out = rs1 - rs2, a don't-care retained for debug.
- HOLD state:
  - result_out, cmp_out and rd_out stay stable while out_valid && !out_ready.
  - On out_ready: if a new accept happens in the same cycle, load the new op; otherwise go to IDLE and drop out_valid.
- Reserved opcodes (14, 15): accepted; result_out=0, cmp_out=0, latency 1.
- flush_in has priority over every other event:
  - Next cycle: state=IDLE, out_valid=0, SHIFT aborted.
  - An accept in the flush cycle is discarded.
  - Data registers keep their values, except that out_valid is cleared.
- rst_in asserted mid-operation: outputs go to their reset values immediately (asynchronous); the partial shift is discarded.
- busy_out=1 only in SHIFT; in_ready=0 in SHIFT.

Test Plan:
- XLEN=32, SERIAL_SHIFT=0: ADD 0xFFFFFFFF+1 -> result 0x00000000 one cycle after accept; SUB 5-7 -> 0xFFFFFFFE.
- Compares: SLT rs1=0x80000000, rs2=1 -> cmp=1, result=1. SLTU same operands -> cmp=0. GEU 3,3 -> cmp=1. NE 3,3 -> cmp=0.
- SERIAL_SHIFT=1, SHIFT_STEP=4: SRA rs1=0x80000000, shamt=31 -> result 0xFFFFFFFF after 9 cycles, busy high for 8 cycles. SLL shamt=0 -> rs1 after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles after XOR 0xF0F0^0x0FF0 -> result 0x0000FF00 stable, in_ready=0. Raise out_ready with a new in_valid in the same cycle -> back-to-back accept, no bubble.
- Flush during serial SRL at cycle 3 of 8 -> out_valid never rises, state IDLE, in_ready=1 on the next cycle. Flush coincident with in_valid -> that op is dropped.
- Assert rst_in mid-SHIFT -> out_valid, busy_out and result_out are 0 before the next clock edge; after release, ADD 2+2 -> 4.
